// File: rtl/p251_mul_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one multi-cycle multiplier.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module p251_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] in_1_flat,
    input  logic [N_REQ*WIDTH-1:0] in_2_flat,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       res,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_in_1,
    output logic [WIDTH-1:0]       mul_in_2,
    input  logic [WIDTH-1:0]       mul_out,
    input  logic                   mul_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   last_q;
    logic [N_REQ-1:0]   ack_q;
    logic [WIDTH-1:0]   res_q;
    logic               busy_q;
    logic               mul_start_q;
    logic [WIDTH-1:0]   mul_in_1_q;
    logic [WIDTH-1:0]   mul_in_2_q;

    logic [IDX_W-1:0]   gnt_d;
    logic               hit_d;
    logic [WIDTH-1:0]   op1_s [N_REQ];
    logic [WIDTH-1:0]   op2_s [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op1_s[g] = in_1_flat[g*WIDTH +: WIDTH];
        assign op2_s[g] = in_2_flat[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: search upward from last_q+1 with wrap, first requester wins.
    always_comb begin
        gnt_d = last_q;
        hit_d = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            logic [IDX_W-1:0] idx_v;
            idx_v = IDX_W'((int'(last_q) + k) % N_REQ);
            if (!hit_d && req[idx_v]) begin
                gnt_d = idx_v;
                hit_d = 1'b1;
            end else begin
                gnt_d = gnt_d;
            end
        end
    end

    // Controller FSM; every output is a register so nothing glitches toward the multiplier or requesters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            ack_q       <= '0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_in_1_q  <= '0;
            mul_in_2_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (hit_d) begin
                        last_q      <= gnt_d;
                        mul_in_1_q  <= op1_s[gnt_d];
                        mul_in_2_q  <= op2_s[gnt_d];
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        mul_start_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                ISSUE: begin
                    mul_start_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // No timeout: the multiplier is trusted to answer eventually.
                    if (mul_done) begin
                        res_q   <= mul_out;
                        ack_q   <= ONE_HOT0 << last_q;
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                RESP: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q       <= '0;
                    busy_q      <= 1'b0;
                    mul_start_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign res       = res_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_in_1  = mul_in_1_q;
    assign mul_in_2  = mul_in_2_q;

endmodule

// File: tb/tb_p251_mul_arbiter.sv
// Directed bench for p251_mul_arbiter; the bench plays the multiplier and drives
// hand-computed mod-251 products.
module tb_p251_mul_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] in_1_flat;
    logic [N*W-1:0] in_2_flat;
    logic [N-1:0]   ack;
    logic [W-1:0]   res;
    logic           busy;
    logic           mul_start;
    logic [W-1:0]   mul_in_1;
    logic [W-1:0]   mul_in_2;
    logic [W-1:0]   mul_out;
    logic           mul_done;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    p251_mul_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_1_flat (in_1_flat),
        .in_2_flat (in_2_flat),
        .ack       (ack),
        .res       (res),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_in_1  (mul_in_1),
        .mul_in_2  (mul_in_2),
        .mul_out   (mul_out),
        .mul_done  (mul_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        in_1_flat[i*W +: W] = a;
        in_2_flat[i*W +: W] = b;
    endtask

    // Called in an IDLE cycle with req already set; returns in the IDLE cycle after ack.
    task automatic serve(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p,
                         input logic [N-1:0] exp_ack, input int hold);
        step();
        chk("issue_start", {31'd0, mul_start}, 32'd1);
        chk("issue_busy", {31'd0, busy}, 32'd1);
        chk("issue_op_a", {24'd0, mul_in_1}, {24'd0, a});
        chk("issue_op_b", {24'd0, mul_in_2}, {24'd0, b});
        step();
        chk("wait_start_low", {31'd0, mul_start}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("wait_hold_busy", {31'd0, busy}, 32'd1);
            chk("wait_hold_ack", {28'd0, ack}, 32'd0);
        end
        mul_out  = p;
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        mul_out  = 8'hEE;
        chk("resp_ack", {28'd0, ack}, {28'd0, exp_ack});
        chk("resp_res", {24'd0, res}, {24'd0, p});
        chk("resp_op_a_held", {24'd0, mul_in_1}, {24'd0, a});
        req = req & ~exp_ack;
        step();
        chk("idle_ack_low", {28'd0, ack}, 32'd0);
        chk("idle_busy_low", {31'd0, busy}, 32'd0);
        chk("idle_res_held", {24'd0, res}, {24'd0, p});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        req       = 4'b0000;
        in_1_flat = 32'd0;
        in_2_flat = 32'd0;
        mul_out   = 8'd0;
        mul_done  = 1'b0;
        #1 rst_n = 1'b0;
        #11 rst_n = 1'b1;
        step();
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_res", {24'd0, res}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, mul_start}, 32'd0);
        chk("rst_in1", {24'd0, mul_in_1}, 32'd0);
        chk("rst_in2", {24'd0, mul_in_2}, 32'd0);

        // Single request: 1 * 20 = 20
        set_ops(0, 8'd1, 8'd20);
        req = 4'b0001;
        serve(8'd1, 8'd20, 8'd20, 4'b0001, 0);

        // Modular wrap: 250 * 250 = 62500 = 249*251 + 1
        set_ops(2, 8'd250, 8'd250);
        req = 4'b0100;
        serve(8'd250, 8'd250, 8'd1, 4'b0100, 2);

        // Spurious mul_done in IDLE
        mul_out  = 8'd77;
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        chk("spur_ack", {28'd0, ack}, 32'd0);
        chk("spur_busy", {31'd0, busy}, 32'd0);
        step();
        chk("spur_ack2", {28'd0, ack}, 32'd0);
        chk("spur_res", {24'd0, res}, 32'd1);

        // Fresh reset, then all four request at once: order 0,1,2,3
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("rst2_res", {24'd0, res}, 32'd0);
        set_ops(0, 8'd3, 8'd4);
        set_ops(1, 8'd5, 8'd6);
        set_ops(2, 8'd16, 8'd16);
        set_ops(3, 8'd100, 8'd3);
        req = 4'b1111;
        serve(8'd3, 8'd4, 8'd12, 4'b0001, 0);
        serve(8'd5, 8'd6, 8'd30, 4'b0010, 1);
        serve(8'd16, 8'd16, 8'd5, 4'b0100, 0);
        serve(8'd100, 8'd3, 8'd49, 4'b1000, 0);

        // Fairness: serve 1, then 1011 -> 3, 0, 1
        req = 4'b0010;
        serve(8'd5, 8'd6, 8'd30, 4'b0010, 0);
        req = 4'b1011;
        serve(8'd100, 8'd3, 8'd49, 4'b1000, 0);
        serve(8'd3, 8'd4, 8'd12, 4'b0001, 0);
        serve(8'd5, 8'd6, 8'd30, 4'b0010, 0);

        // Reset during WAIT
        req = 4'b0001;
        step();
        chk("mid_issue", {31'd0, mul_start}, 32'd1);
        step();
        chk("mid_wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in1", {24'd0, mul_in_1}, 32'd0);
        chk("mid_rst_res", {24'd0, res}, 32'd0);
        chk("mid_rst_ack", {28'd0, ack}, 32'd0);
        req = 4'b0000;
        #2 rst_n = 1'b1;
        step();
        mul_out  = 8'd99;
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        chk("late_done_ack", {28'd0, ack}, 32'd0);
        chk("late_done_busy", {31'd0, busy}, 32'd0);
        step();
        chk("late_done_res", {24'd0, res}, 32'd0);
        req = 4'b0001;
        serve(8'd3, 8'd4, 8'd12, 4'b0001, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/p251_mul_arbiter.md
P251_MUL_ARBITER -- requirements
Module: p251_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  N_REQ  per-requester request; held high until ack.
REQ-006 SHALL have port in_1_flat  input  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_2_flat  input  N_REQ*WIDTH  operand B; same packing as in_1_flat.
REQ-008 SHALL have port ack  output  N_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-009 SHALL have port res  output  WIDTH  product; valid in the cycle ack is high.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-012 SHALL have port mul_in_1  output  WIDTH  operand A to the multiplier; registered.
REQ-013 SHALL have port mul_in_2  output  WIDTH  operand B to the multiplier; registered.
REQ-014 SHALL have port mul_out  input  WIDTH  multiplier result.
REQ-015 SHALL have port mul_done  input  1  multiplier completion pulse; mul_out valid in the same cycle.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-017 SHALL stay in IDLE while req is all-zero.
REQ-018 SHALL leave IDLE when any req bit is high at a clock edge, and at that edge:
  - grant one requester using round-robin priority;
  - register its operands into mul_in_1 and mul_in_2;
  - enter ISSUE.
REQ-019 SHALL apply round-robin priority starting at (last_grant+1) mod N_REQ, searching upward with wrap-around; last_grant updates only on grant.
REQ-020 SHALL, in ISSUE, drive mul_start=1 for exactly one cycle, then enter WAIT.
REQ-021 SHALL hold mul_in_1 and mul_in_2 stable from ISSUE through RESP.
REQ-022 SHALL, in WAIT, capture mul_out into res and enter RESP at the edge where mul_done=1; with mul_done=0 it stays in WAIT with no timeout.
REQ-023 SHALL, in RESP, drive ack[grant]=1 for exactly one cycle with res valid, then return to IDLE.
REQ-024 SHALL not sample req in ISSUE, WAIT or RESP. A requester deasserts req at the edge ending its ack cycle.
REQ-025 SHALL have a minimum latency of 3 cycles + multiplier latency, measured from the grant edge to the ack cycle.
REQ-026 SHALL ignore mul_done in IDLE, ISSUE and RESP.
REQ-027 SHALL complete an operation and pulse ack even if the granted req drops mid-operation; the result is then discarded by the requester.
REQ-028 SHALL hold res at its last captured value outside the ack cycle.
REQ-029 SHALL never drive more than one ack bit high, and SHALL never assert mul_start outside ISSUE.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-operation, asynchronously reset:
  - state to IDLE;
  - ack, res, mul_start, mul_in_1, mul_in_2 and busy to 0;
  - last_grant to N_REQ-1, so requester 0 has first priority.
REQ-031 SHALL, after reset release, re-evaluate req from IDLE. An operation interrupted by reset produces no ack.

Verification
REQ-032 Single request, with p251_mul attached: req=0001, in_1=1, in_2=20 -> mul_start one pulse; ack=0001 with res=20; busy low the cycle after ack.
REQ-033 Modular wrap: requester 2 with in_1=250, in_2=250 -> ack=0100, res=1 (mod 251).
REQ-034 All four requesters high from reset, each dropping req after its ack -> ack order 0,1,2,3, one operation at a time.
REQ-035 Fairness: requester 1 served, then req=1011 -> next grant is 3, then 0, then 1.
REQ-036 Reset mid-operation: rst_n low during WAIT -> all outputs 0 immediately; a later mul_done produces no ack; after release, req=0001 -> normal completion.
REQ-037 Spurious mul_done pulsed in IDLE -> no state change, no ack; mul_done held low in WAIT -> stays in WAIT, busy=1.
